instr_cache_assoc: RTL and testbench

INSTR_CACHE_ASSOC -- requirements
Module: instr_cache_assoc

---
 rtl/instr_cache_assoc.sv | 176 +++++++++++++++++
 tb/tb_instr_cache_assoc.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_cache_assoc.sv
// Multi-port set-associative instruction cache with registered lookup, FIFO replacement
// and a single shared line-refill engine arbitrated round-robin across fetch ports.
module instr_cache_assoc #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned SETS  = 8,
  parameter int unsigned WAYS  = 2,
  parameter int unsigned WORDS = 4,
  parameter int unsigned PORTS = 2
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            flush,
  input  logic [PORTS-1:0]                read,
  input  logic [PORTS-1:0][XLEN-1:0]      address,
  output logic [PORTS-1:0]                hit,
  output logic [PORTS-1:0][XLEN-1:0]      instr,
  output logic                            mem_read,
  output logic [XLEN-1:0]                 mem_address,
  input  logic [WORDS-1:0][XLEN-1:0]      mem_data,
  input  logic                            mem_ready
);

  localparam int unsigned OffW    = $clog2(WORDS);
  localparam int unsigned IdxW    = $clog2(SETS);
  localparam int unsigned LineLsb = 2 + OffW;
  localparam int unsigned TagLsb  = LineLsb + IdxW;
  localparam int unsigned TagW    = XLEN - TagLsb;
  localparam int unsigned LineW   = XLEN - LineLsb;
  localparam int unsigned WayW    = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int unsigned PortW   = (PORTS > 1) ? $clog2(PORTS) : 1;

  typedef enum logic [0:0] {StIdle, StRequest} state_e;

  state_e                         state_q;
  logic [WAYS-1:0]                valid_q  [SETS];
  logic [TagW-1:0]                tag_q    [SETS][WAYS];
  logic [WORDS-1:0][XLEN-1:0]     data_q   [SETS][WAYS];
  logic [WayW-1:0]                victim_q [SETS];
  logic [LineW-1:0]               line_q;
  logic [PortW-1:0]               rr_q;
  logic                           flush_pend_q;
  logic [PORTS-1:0]               hit_q;
  logic [PORTS-1:0][XLEN-1:0]     instr_q;
  logic                           mem_read_q;
  logic [XLEN-1:0]                mem_address_q;

  logic [PORTS-1:0][OffW-1:0]     p_off;
  logic [PORTS-1:0][IdxW-1:0]     p_idx;
  logic [PORTS-1:0][TagW-1:0]     p_tag;
  logic [PORTS-1:0]               match;
  logic [PORTS-1:0][XLEN-1:0]     word;
  logic [PORTS-1:0]               miss;
  logic                           sel_valid;
  logic [PortW-1:0]               sel_port;
  logic [LineW-1:0]               sel_line;
  logic                           clear;
  logic [IdxW-1:0]                fill_idx;
  logic [TagW-1:0]                fill_tag;
  logic                           has_inv;
  logic [WayW-1:0]                vict;
  logic [WayW-1:0]                vict_next;
  logic                           fill;

  assign hit         = hit_q;
  assign instr       = instr_q;
  assign mem_read    = mem_read_q;
  assign mem_address = mem_address_q;

  for (genvar p = 0; p < PORTS; p++) begin : g_split
    assign p_off[p] = address[p][LineLsb-1:2];
    assign p_idx[p] = address[p][TagLsb-1:LineLsb];
    assign p_tag[p] = address[p][XLEN-1:TagLsb];
  end

  always_comb begin
    match = '0;
    word  = '0;
    for (int p = 0; p < PORTS; p++) begin
      for (int w = 0; w < WAYS; w++) begin
        if (valid_q[p_idx[p]][w] && (tag_q[p_idx[p]][w] == p_tag[p])) begin
          match[p] = 1'b1;
          word[p]  = data_q[p_idx[p]][w][p_off[p]];
        end
      end
    end
  end

  assign miss  = read & ~match;
  assign clear = (state_q == StIdle) && (flush || flush_pend_q);

  // Search begins at rr_q, which always points just past the last-served port.
  always_comb begin
    sel_valid = 1'b0;
    sel_port  = '0;
    for (int i = 0; i < PORTS; i++) begin
      if (!sel_valid && miss[(int'(rr_q) + i) % int'(PORTS)]) begin
        sel_valid = 1'b1;
        sel_port  = PortW'((int'(rr_q) + i) % int'(PORTS));
      end
    end
  end

  assign sel_line = address[sel_port][XLEN-1:LineLsb];
  assign fill_idx = line_q[IdxW-1:0];
  assign fill_tag = line_q[LineW-1:IdxW];
  assign fill     = (state_q == StRequest) && mem_ready;

  // Descending scan so the lowest-index invalid way wins.
  always_comb begin
    has_inv = 1'b0;
    vict    = victim_q[fill_idx];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[fill_idx][w]) begin
        has_inv = 1'b1;
        vict    = WayW'(w);
      end
    end
  end

  assign vict_next = (victim_q[fill_idx] == WayW'(WAYS - 1)) ? '0 : victim_q[fill_idx] + 1'b1;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= StIdle;
      flush_pend_q  <= 1'b0;
      rr_q          <= '0;
      line_q        <= '0;
      hit_q         <= '0;
      instr_q       <= '0;
      mem_read_q    <= 1'b0;
      mem_address_q <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s]  <= '0;
        victim_q[s] <= '0;
      end
    end else begin
      hit_q   <= read & match & {PORTS{~clear}};
      instr_q <= word;
      case (state_q)
        StIdle: begin
          if (clear) begin
            flush_pend_q <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
              valid_q[s]  <= '0;
              victim_q[s] <= '0;
            end
          end else if (sel_valid) begin
            line_q        <= sel_line;
            mem_read_q    <= 1'b1;
            mem_address_q <= {sel_line, {LineLsb{1'b0}}};
            rr_q          <= (sel_port == PortW'(PORTS - 1)) ? '0 : sel_port + 1'b1;
            state_q       <= StRequest;
          end
        end
        StRequest: begin
          if (flush) flush_pend_q <= 1'b1;
          if (mem_ready) begin
            valid_q[fill_idx][vict] <= 1'b1;
            if (!has_inv) victim_q[fill_idx] <= vict_next;
            mem_read_q <= 1'b0;
            state_q    <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && fill) begin
      tag_q[fill_idx][vict]  <= fill_tag;
      data_q[fill_idx][vict] <= mem_data;
    end
  end

endmodule

// File: tb/tb_instr_cache_assoc.sv
// Directed bench for instr_cache_assoc: refill, sharing, eviction, arbitration, flush, reset.
module tb_instr_cache_assoc;

  logic              clock = 1'b0;
  logic              reset;
  logic              flush;
  logic [1:0]        read;
  logic [1:0][31:0]  address;
  logic [1:0]        hit;
  logic [1:0][31:0]  instr;
  logic              mem_read;
  logic [31:0]       mem_address;
  logic [3:0][31:0]  mem_data;
  logic              mem_ready;

  int checks = 0;
  int errors = 0;
  int refills = 0;

  instr_cache_assoc dut (
    .clock       (clock),
    .reset       (reset),
    .flush       (flush),
    .read        (read),
    .address     (address),
    .hit         (hit),
    .instr       (instr),
    .mem_read    (mem_read),
    .mem_address (mem_address),
    .mem_data    (mem_data),
    .mem_ready   (mem_ready)
  );

  always #5 clock = ~clock;

  always @(posedge clock) if (!reset && mem_read && mem_ready) refills <= refills + 1;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; flush = 1'b0; read = '0; address = '0; mem_ready = 1'b0; mem_data = '0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic wait_mem(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mem_read === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic give_line(input logic [31:0] w0, w1, w2, w3);
    mem_data = {w3, w2, w1, w0};
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    mem_data = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; read = 2'b11; mem_ready = 1'b0; mem_data = '0;
    address[0] = 32'h100; address[1] = 32'h200;
    tick();
    checks++; if (hit !== 2'b00) begin errors++; $display("FAIL reset_hit got %b want 00", hit); end
    checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL reset_mem_read got %b want 0", mem_read); end
    checks++; if (mem_address !== 32'h0) begin errors++; $display("FAIL reset_mem_address got %h want 0", mem_address); end
    checks++; if (instr !== 64'h0) begin errors++; $display("FAIL reset_instr got %h want 0", instr); end
    reset = 1'b0; read = '0;
    tick();
  endtask

  task automatic test_cold_miss();
    int r0;
    do_reset();
    r0 = refills;
    read = 2'b01; address[0] = 32'h104;
    tick();
    checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL cold_mem_read got %b want 1", mem_read); end
    checks++; if (mem_address !== 32'h100) begin errors++; $display("FAIL cold_mem_address got %h want 00000100", mem_address); end
    checks++; if (hit[0] !== 1'b0) begin errors++; $display("FAIL cold_hit_miss got %b want 0", hit[0]); end
    give_line(32'h11, 32'h22, 32'h33, 32'h44);
    checks++; if (hit[0] !== 1'b0) begin errors++; $display("FAIL cold_prefill_hit got %b want 0", hit[0]); end
    checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL cold_mem_read_drop got %b want 0", mem_read); end
    tick();
    checks++; if (hit[0] !== 1'b1 || instr[0] !== 32'h22) begin
      errors++; $display("FAIL cold_hit got hit=%b instr=%h want hit=1 instr=00000022", hit[0], instr[0]);
    end
    tick();
    checks++; if (refills - r0 !== 1) begin errors++; $display("FAIL cold_refills got %0d want 1", refills - r0); end
    read = '0;
    tick();
    checks++; if (hit !== 2'b00) begin errors++; $display("FAIL cold_idle_hit got %b want 00", hit); end
  endtask

  task automatic test_shared_miss();
    int r0;
    do_reset();
    r0 = refills;
    read = 2'b11; address[0] = 32'h100; address[1] = 32'h10C;
    tick();
    checks++; if (mem_address !== 32'h100) begin errors++; $display("FAIL shared_mem_address got %h want 00000100", mem_address); end
    give_line(32'h11, 32'h22, 32'h33, 32'h44);
    tick();
    checks++; if (hit !== 2'b11 || instr[0] !== 32'h11 || instr[1] !== 32'h44) begin
      errors++; $display("FAIL shared_hit got hit=%b i0=%h i1=%h want 11 00000011 00000044", hit, instr[0], instr[1]);
    end
    checks++; if (refills - r0 !== 1 || mem_read !== 1'b0) begin
      errors++; $display("FAIL shared_one_refill got refills=%0d mem_read=%b want 1 0", refills - r0, mem_read);
    end
    address[1] = 32'h104;
    tick();
    checks++; if (hit !== 2'b11 || instr[1] !== 32'h22) begin
      errors++; $display("FAIL shared_same_line got hit=%b i1=%h want 11 00000022", hit, instr[1]);
    end
    read = '0;
  endtask

  task automatic test_eviction();
    logic [31:0] lines [3];
    bit ok;
    lines[0] = 32'h100; lines[1] = 32'h180; lines[2] = 32'h200;
    do_reset();
    read = 2'b01;
    for (int i = 0; i < 3; i++) begin
      address[0] = lines[i];
      wait_mem(ok);
      checks++; if (!ok || mem_address !== lines[i]) begin
        errors++; $display("FAIL evict_fill%0d got ok=%b addr=%h want 1 %h", i, ok, mem_address, lines[i]);
      end
      give_line(lines[i] + 1, lines[i] + 2, lines[i] + 3, lines[i] + 4);
      tick();
      checks++; if (hit[0] !== 1'b1 || instr[0] !== lines[i] + 1) begin
        errors++; $display("FAIL evict_hit%0d got hit=%b instr=%h want 1 %h", i, hit[0], instr[0], lines[i] + 1);
      end
    end
    address[0] = 32'h188;
    tick();
    checks++; if (hit[0] !== 1'b1 || instr[0] !== 32'h183) begin
      errors++; $display("FAIL evict_keep_180 got hit=%b instr=%h want 1 00000183", hit[0], instr[0]);
    end
    address[0] = 32'h100;
    tick();
    checks++; if (hit[0] !== 1'b0 || mem_read !== 1'b1 || mem_address !== 32'h100) begin
      errors++; $display("FAIL evict_100_gone got hit=%b mem_read=%b addr=%h want 0 1 00000100", hit[0], mem_read, mem_address);
    end
    give_line(32'h101, 32'h102, 32'h103, 32'h104);
    address[0] = 32'h200;
    tick();
    checks++; if (hit[0] !== 1'b1 || instr[0] !== 32'h201) begin
      errors++; $display("FAIL evict_keep_200 got hit=%b instr=%h want 1 00000201", hit[0], instr[0]);
    end
    read = '0;
  endtask

  task automatic test_round_robin();
    bit ok;
    do_reset();
    read = 2'b11; address[0] = 32'h100; address[1] = 32'h210;
    wait_mem(ok);
    checks++; if (!ok || mem_address !== 32'h100) begin errors++; $display("FAIL rr1_first got ok=%b addr=%h want 1 00000100", ok, mem_address); end
    give_line(32'ha0, 32'ha1, 32'ha2, 32'ha3);
    wait_mem(ok);
    checks++; if (!ok || mem_address !== 32'h210) begin errors++; $display("FAIL rr1_second got ok=%b addr=%h want 1 00000210", ok, mem_address); end
    give_line(32'hb0, 32'hb1, 32'hb2, 32'hb3);
    tick();
    checks++; if (hit !== 2'b11 || instr[1] !== 32'hb0) begin errors++; $display("FAIL rr1_hits got hit=%b i1=%h want 11 000000b0", hit, instr[1]); end
    // Lone port0 miss makes port0 the last-served port.
    read = 2'b01; address[0] = 32'h400;
    wait_mem(ok);
    give_line(32'hc0, 32'hc1, 32'hc2, 32'hc3);
    read = 2'b11; address[0] = 32'h480; address[1] = 32'h520;
    wait_mem(ok);
    checks++; if (!ok || mem_address !== 32'h520) begin errors++; $display("FAIL rr2_first got ok=%b addr=%h want 1 00000520", ok, mem_address); end
    give_line(32'hd0, 32'hd1, 32'hd2, 32'hd3);
    wait_mem(ok);
    checks++; if (!ok || mem_address !== 32'h480) begin errors++; $display("FAIL rr2_second got ok=%b addr=%h want 1 00000480", ok, mem_address); end
    give_line(32'he0, 32'he1, 32'he2, 32'he3);
    tick();
    checks++; if (hit !== 2'b11 || instr[0] !== 32'he0 || instr[1] !== 32'hd0) begin
      errors++; $display("FAIL rr2_hits got hit=%b i0=%h i1=%h want 11 000000e0 000000d0", hit, instr[0], instr[1]);
    end
    read = '0;
  endtask

  task automatic test_flush();
    bit ok;
    do_reset();
    read = 2'b01; address[0] = 32'h100;
    wait_mem(ok);
    give_line(32'h11, 32'h22, 32'h33, 32'h44);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (hit[0] !== 1'b0) begin errors++; $display("FAIL flush_idle_hit got %b want 0", hit[0]); end
    tick();
    checks++; if (mem_read !== 1'b1 || mem_address !== 32'h100) begin
      errors++; $display("FAIL flush_idle_remiss got mem_read=%b addr=%h want 1 00000100", mem_read, mem_address);
    end
    give_line(32'h11, 32'h22, 32'h33, 32'h44);
    address[0] = 32'h300;
    wait_mem(ok);
    checks++; if (!ok || mem_address !== 32'h300) begin errors++; $display("FAIL flush_req_addr got ok=%b addr=%h want 1 00000300", ok, mem_address); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL flush_req_hold got %b want 1", mem_read); end
    give_line(32'h301, 32'h302, 32'h303, 32'h304);
    tick();
    checks++; if (hit[0] !== 1'b0 || mem_read !== 1'b0) begin
      errors++; $display("FAIL flush_pending_clear got hit=%b mem_read=%b want 0 0", hit[0], mem_read);
    end
    tick();
    checks++; if (mem_read !== 1'b1 || mem_address !== 32'h300) begin
      errors++; $display("FAIL flush_300_remiss got mem_read=%b addr=%h want 1 00000300", mem_read, mem_address);
    end
    give_line(32'h301, 32'h302, 32'h303, 32'h304);
    tick();
    checks++; if (hit[0] !== 1'b1 || instr[0] !== 32'h301) begin
      errors++; $display("FAIL flush_300_hit got hit=%b instr=%h want 1 00000301", hit[0], instr[0]);
    end
    read = '0;
  endtask

  task automatic test_reset_mid_refill();
    bit ok;
    do_reset();
    read = 2'b01; address[0] = 32'h100;
    wait_mem(ok);
    give_line(32'h11, 32'h22, 32'h33, 32'h44);
    tick();
    checks++; if (hit[0] !== 1'b1) begin errors++; $display("FAIL rstmid_prefill_hit got %b want 1", hit[0]); end
    read = 2'b10; address[1] = 32'h180;
    wait_mem(ok);
    checks++; if (!ok || mem_address !== 32'h180) begin errors++; $display("FAIL rstmid_req got ok=%b addr=%h want 1 00000180", ok, mem_address); end
    reset = 1'b1; read = '0;
    tick();
    reset = 1'b0;
    checks++; if (mem_read !== 1'b0 || mem_address !== 32'h0) begin
      errors++; $display("FAIL rstmid_abandon got mem_read=%b addr=%h want 0 00000000", mem_read, mem_address);
    end
    give_line(32'h181, 32'h182, 32'h183, 32'h184);
    checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL rstmid_late_ready got %b want 0", mem_read); end
    read = 2'b11; address[0] = 32'h100; address[1] = 32'h180;
    tick();
    checks++; if (hit !== 2'b00 || mem_read !== 1'b1 || mem_address !== 32'h100) begin
      errors++; $display("FAIL rstmid_100_miss got hit=%b mem_read=%b addr=%h want 00 1 00000100", hit, mem_read, mem_address);
    end
    give_line(32'h11, 32'h22, 32'h33, 32'h44);
    read = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_shared_miss();
    test_eviction();
    test_round_robin();
    test_flush();
    test_reset_mid_refill();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
